// File: rtl/cdb_completion_fifo_if.sv
// Completion-side and broadcast-side signals of the CDB completion FIFO.
// The master modport is the environment; the slave modport is the FIFO.
interface cdb_completion_fifo_if #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic [NUM_CH-1:0]        IN_VALID;
  logic [NUM_CH*TAG_W-1:0]  IN_TAG;
  logic [NUM_CH*DATA_W-1:0] IN_DATA;
  logic                     IN_READY;
  logic                     FLUSH;
  logic                     CDB_READY;
  logic                     CDB_VALID;
  logic [TAG_W-1:0]         CDB_TAG;
  logic [DATA_W-1:0]        CDB_DATA;
  logic [$clog2(DEPTH):0]   COUNT;
  logic                     OVERFLOW;

  modport master (
    output IN_VALID, IN_TAG, IN_DATA, FLUSH, CDB_READY,
    input  IN_READY, CDB_VALID, CDB_TAG, CDB_DATA, COUNT, OVERFLOW
  );

  modport slave (
    input  IN_VALID, IN_TAG, IN_DATA, FLUSH, CDB_READY,
    output IN_READY, CDB_VALID, CDB_TAG, CDB_DATA, COUNT, OVERFLOW
  );
endinterface

// File: rtl/cdb_completion_fifo.sv
// Multi-channel completion queue feeding a single common data bus broadcast.
// Up to NUM_CH pushes per cycle in channel order, one pop per cycle.
module cdb_completion_fifo #(
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  cdb_completion_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [TAG_W+DATA_W-1:0] mem [DEPTH];
  logic [TAG_W+DATA_W-1:0] head_ent;

  ptr_t head, tail;
  cnt_t count;
  logic overflow;

  ptr_t slot [NUM_CH];
  cnt_t push_cnt;
  logic in_ready, cdb_valid, do_push, do_pop;

  assign in_ready  = (cnt_t'(DEPTH) - count) >= cnt_t'(NUM_CH);
  assign cdb_valid = (count != '0);
  assign do_push   = in_ready && !bus.FLUSH;
  // cdb_valid comes from the registered count, so a push into an empty queue is never popped the same edge
  assign do_pop    = cdb_valid && bus.CDB_READY && !bus.FLUSH;

  // Prefix count of valid channels gives each channel its tail offset.
  always_comb begin
    cnt_t run;
    run = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      slot[i] = tail + run[AW-1:0];
      if (bus.IN_VALID[i]) run = run + cnt_t'(1);
    end
    push_cnt = run;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (!in_ready && (|bus.IN_VALID)) overflow <= 1'b1;
      if (bus.FLUSH) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) tail <= tail + push_cnt[AW-1:0];
        if (do_pop)  head <= head + ptr_t'(1);
        count <= count + (do_push ? push_cnt : '0) - cnt_t'(do_pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (bus.IN_VALID[i])
          mem[slot[i]] <= {bus.IN_TAG[i*TAG_W +: TAG_W], bus.IN_DATA[i*DATA_W +: DATA_W]};
      end
    end
  end

  assign head_ent      = cdb_valid ? mem[head] : '0;
  assign bus.CDB_VALID = cdb_valid;
  assign bus.CDB_TAG   = head_ent[DATA_W +: TAG_W];
  assign bus.CDB_DATA  = head_ent[DATA_W-1:0];
  assign bus.IN_READY  = in_ready;
  assign bus.COUNT     = count;
  assign bus.OVERFLOW  = overflow;
endmodule

// File: tb/tb_cdb_completion_fifo.sv
// Scoreboard bench for cdb_completion_fifo: expected entries are queued as pushes
// are driven and compared against the broadcast head as it is consumed.
module tb_cdb_completion_fifo;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 16;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  cdb_completion_fifo_if #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) b ();

  cdb_completion_fifo #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (b)
  );

  ent_t exp_q[$];
  logic exp_ovf;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   seq      = 1;

  task automatic idle();
    b.IN_VALID = '0;
    b.FLUSH    = 1'b0;
  endtask

  task automatic drive_in(input logic [NUM_CH-1:0] v);
    b.IN_VALID = v;
    for (int i = 0; i < NUM_CH; i++) begin
      b.IN_TAG[i*TAG_W +: TAG_W]    = TAG_W'(seq);
      b.IN_DATA[i*DATA_W +: DATA_W] = 32'hC0DE_0000 + DATA_W'(seq);
      seq++;
    end
  endtask

  // Advance the reference queue with the inputs about to be sampled, then cross the edge.
  task automatic tick();
    bit pop, rdy;
    rdy = (DEPTH - exp_q.size()) >= NUM_CH;
    pop = (exp_q.size() != 0) && (b.CDB_READY === 1'b1);
    if (!rdy && (|b.IN_VALID)) exp_ovf = 1'b1;
    if (b.FLUSH === 1'b1) exp_q.delete();
    else begin
      if (pop) void'(exp_q.pop_front());
      if (rdy)
        for (int i = 0; i < NUM_CH; i++)
          if (b.IN_VALID[i])
            exp_q.push_back('{tag: b.IN_TAG[i*TAG_W +: TAG_W], data: b.IN_DATA[i*DATA_W +: DATA_W]});
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    idle();
    b.CDB_READY = 1'b0;
    b.IN_TAG    = '0;
    b.IN_DATA   = '0;
    RST = 1'b0;
    #1 RST = 1'b1;
    #2;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_checks++;
    if (b.COUNT !== 5'd0 || b.CDB_VALID !== 1'b0) $display("FAIL reset_count: count=%0d valid=%b want 0/0", b.COUNT, b.CDB_VALID);
    else n_pass++;
    n_checks++;
    if (b.CDB_TAG !== '0 || b.CDB_DATA !== '0) $display("FAIL reset_cdb: tag=%0h data=%0h want 0/0", b.CDB_TAG, b.CDB_DATA);
    else n_pass++;
    n_checks++;
    if (b.IN_READY !== 1'b1 || b.OVERFLOW !== 1'b0) $display("FAIL reset_flags: in_ready=%b overflow=%b want 1/0", b.IN_READY, b.OVERFLOW);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_two_channel();
    b.CDB_READY = 1'b1;
    drive_in(4'b0000);
    b.IN_VALID = 4'b1010;
    b.IN_TAG[1*TAG_W +: TAG_W]    = 4'd3;
    b.IN_DATA[1*DATA_W +: DATA_W] = 32'hA;
    b.IN_TAG[3*TAG_W +: TAG_W]    = 4'd5;
    b.IN_DATA[3*DATA_W +: DATA_W] = 32'hB;
    tick();
    idle();
    n_checks++;
    if (b.CDB_VALID !== 1'b1 || b.CDB_TAG !== 4'd3 || b.CDB_DATA !== 32'hA || b.COUNT !== 5'd2)
      $display("FAIL two_ch_first: valid=%b tag=%0d data=%0h count=%0d want 1/3/a/2", b.CDB_VALID, b.CDB_TAG, b.CDB_DATA, b.COUNT);
    else n_pass++;
    tick();
    n_checks++;
    if (b.CDB_TAG !== 4'd5 || b.CDB_DATA !== 32'hB || b.COUNT !== 5'd1)
      $display("FAIL two_ch_second: tag=%0d data=%0h count=%0d want 5/b/1", b.CDB_TAG, b.CDB_DATA, b.COUNT);
    else n_pass++;
    tick();
    n_checks++;
    if (b.CDB_VALID !== 1'b0 || b.COUNT !== 5'd0 || b.CDB_TAG !== '0 || b.CDB_DATA !== '0)
      $display("FAIL two_ch_empty: valid=%b count=%0d tag=%0h data=%0h want 0/0/0/0", b.CDB_VALID, b.COUNT, b.CDB_TAG, b.CDB_DATA);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    ent_t first;
    b.CDB_READY = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive_in(4'b1111);
      tick();
      if (c == 0) first = exp_q[0];
      n_checks++;
      if (b.CDB_VALID !== 1'b1 || {b.CDB_TAG, b.CDB_DATA} !== first)
        $display("FAIL bp_hold_%0d: head=%0h want %0h", c, {b.CDB_TAG, b.CDB_DATA}, first);
      else n_pass++;
      if (c == 2) begin
        n_checks++;
        if (b.COUNT !== 5'd12 || b.IN_READY !== 1'b1) $display("FAIL bp_12: count=%0d in_ready=%b want 12/1", b.COUNT, b.IN_READY);
        else n_pass++;
      end
    end
    idle();
    n_checks++;
    if (b.COUNT !== 5'd16 || b.IN_READY !== 1'b0) $display("FAIL bp_full: count=%0d in_ready=%b want 16/0", b.COUNT, b.IN_READY);
    else n_pass++;
    b.CDB_READY = 1'b1;
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if ({b.CDB_TAG, b.CDB_DATA} !== exp_q[0] || b.COUNT !== 5'(exp_q.size()))
        $display("FAIL bp_drain_%0d: head=%0h count=%0d want %0h/%0d", k, {b.CDB_TAG, b.CDB_DATA}, b.COUNT, exp_q[0], exp_q.size());
      else n_pass++;
      tick();
    end
    n_checks++;
    if (b.CDB_VALID !== 1'b0 || b.COUNT !== 5'd0) $display("FAIL bp_empty: valid=%b count=%0d want 0/0", b.CDB_VALID, b.COUNT);
    else n_pass++;
  endtask

  task automatic test_overflow();
    b.CDB_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_in(4'b1111);
      tick();
    end
    drive_in(4'b0001);
    tick();
    drive_in(4'b1111);
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd13 || b.COUNT !== 5'(exp_q.size()) || b.IN_READY !== 1'b0)
      $display("FAIL ovf_count: count=%0d in_ready=%b want 13/0", b.COUNT, b.IN_READY);
    else n_pass++;
    n_checks++;
    if (b.OVERFLOW !== 1'b1 || b.OVERFLOW !== exp_ovf) $display("FAIL ovf_set: overflow=%b want 1", b.OVERFLOW);
    else n_pass++;
    b.FLUSH = 1'b1;
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd0 || b.OVERFLOW !== 1'b1) $display("FAIL ovf_after_flush: count=%0d overflow=%b want 0/1", b.COUNT, b.OVERFLOW);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_checks++;
    if (b.OVERFLOW !== 1'b0) $display("FAIL ovf_cleared_by_rst: overflow=%b want 0", b.OVERFLOW);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic test_wrap();
    b.CDB_READY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_in(4'b1111);
      tick();
    end
    drive_in(4'b0011);
    tick();
    idle();
    b.CDB_READY = 1'b1;
    for (int k = 0; k < 14; k++) tick();
    b.CDB_READY = 1'b0;
    n_checks++;
    if (b.COUNT !== 5'd0) $display("FAIL wrap_align: count=%0d want 0", b.COUNT);
    else n_pass++;
    drive_in(4'b1111);
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd4) $display("FAIL wrap_count: count=%0d want 4", b.COUNT);
    else n_pass++;
    b.CDB_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (b.CDB_VALID !== 1'b1 || {b.CDB_TAG, b.CDB_DATA} !== exp_q[0])
        $display("FAIL wrap_pop_%0d: head=%0h want %0h", k, {b.CDB_TAG, b.CDB_DATA}, exp_q[0]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (b.CDB_VALID !== 1'b0) $display("FAIL wrap_empty: valid=%b want 0", b.CDB_VALID);
    else n_pass++;
  endtask

  task automatic test_flush();
    b.CDB_READY = 1'b0;
    drive_in(4'b1111);
    tick();
    drive_in(4'b0001);
    tick();
    n_checks++;
    if (b.COUNT !== 5'd5) $display("FAIL flush_pre: count=%0d want 5", b.COUNT);
    else n_pass++;
    drive_in(4'b1111);
    b.FLUSH     = 1'b1;
    b.CDB_READY = 1'b1;
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd0 || b.CDB_VALID !== 1'b0 || b.CDB_TAG !== '0 || b.CDB_DATA !== '0)
      $display("FAIL flush_clear: count=%0d valid=%b tag=%0h data=%0h want 0/0/0/0", b.COUNT, b.CDB_VALID, b.CDB_TAG, b.CDB_DATA);
    else n_pass++;
    drive_in(4'b0100);
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd1 || {b.CDB_TAG, b.CDB_DATA} !== exp_q[0])
      $display("FAIL flush_resume: count=%0d head=%0h want 1/%0h", b.COUNT, {b.CDB_TAG, b.CDB_DATA}, exp_q[0]);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    b.CDB_READY = 1'b0;
    drive_in(4'b1111);
    tick();
    drive_in(4'b0111);
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd7) $display("FAIL arst_pre: count=%0d want 7", b.COUNT);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    n_checks++;
    if (b.COUNT !== 5'd0 || b.CDB_VALID !== 1'b0 || b.IN_READY !== 1'b1 || b.CDB_TAG !== '0)
      $display("FAIL arst_now: count=%0d valid=%b in_ready=%b tag=%0h want 0/0/1/0", b.COUNT, b.CDB_VALID, b.IN_READY, b.CDB_TAG);
    else n_pass++;
    @(negedge CLK);
    RST = 1'b0;
    drive_in(4'b0001);
    tick();
    idle();
    n_checks++;
    if (b.COUNT !== 5'd1 || {b.CDB_TAG, b.CDB_DATA} !== exp_q[0])
      $display("FAIL arst_resume: count=%0d head=%0h want 1/%0h", b.COUNT, {b.CDB_TAG, b.CDB_DATA}, exp_q[0]);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_two_channel();
    test_backpressure();
    test_overflow();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cdb_completion_fifo.md
CDB_COMPLETION_FIFO -- requirements
Module: cdb_completion_fifo

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, the number of functional-unit completion channels.
REQ-002 The block SHALL have parameter DEPTH, default 16, the entry count, a power of two with DEPTH >= 2*NUM_CH.
REQ-003 The block SHALL have parameter DATA_W, default 32, the result width.
REQ-004 The block SHALL have parameter TAG_W, default 4, the reservation-station tag width.
REQ-005 The block SHALL have port CLK input 1, the single clock; all state updates on the rising edge.
REQ-006 The block SHALL have port RST input 1, the reset; asynchronous and active-high.
REQ-007 The block SHALL have port IN_VALID input NUM_CH, per-channel completion request.
REQ-008 The block SHALL have port IN_TAG input NUM_CH*TAG_W, channel i in bits [i*TAG_W +: TAG_W].
REQ-009 The block SHALL have port IN_DATA input NUM_CH*DATA_W, channel i in bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port IN_READY output 1, high when the free entries are >= NUM_CH.
REQ-011 The block SHALL have port FLUSH input 1, a synchronous discard of all queued entries.
REQ-012 The block SHALL have port CDB_READY input 1, the consumer accepts the current broadcast.
REQ-013 The block SHALL have port CDB_VALID output 1, the head entry is being broadcast.
REQ-014 The block SHALL have port CDB_TAG output TAG_W, the head entry tag.
REQ-015 The block SHALL have port CDB_DATA output DATA_W, the head entry data.
REQ-016 The block SHALL have port COUNT output $clog2(DEPTH)+1, the number of occupied entries.
REQ-017 The block SHALL have port OVERFLOW output 1, a sticky flag set when completions arrive while IN_READY is low.

Function
REQ-018 The block SHALL be a synthesizable circular buffer with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH; simulation-only queue constructs are not used.
REQ-019 On an edge with IN_READY high, each channel with IN_VALID[i]=1 SHALL be written at consecutive tail slots in ascending channel index, skipping invalid channels, so up to NUM_CH pushes occur per cycle.
REQ-020 An edge with IN_READY low SHALL write no entries, SHALL leave the tail unchanged, and SHALL set OVERFLOW if any IN_VALID bit is 1.
REQ-021 IN_READY SHALL be combinational from registered COUNT only: (DEPTH - COUNT) >= NUM_CH.
REQ-022 CDB_VALID SHALL equal (COUNT != 0); CDB_TAG/CDB_DATA SHALL present the head entry when valid and all-zero when empty.
REQ-023 A pop SHALL occur on an edge where CDB_VALID && CDB_READY, advancing the head by one; at most one pop per cycle.
REQ-024 Latency: an entry pushed at edge k into an empty queue SHALL appear on CDB outputs after edge k (one cycle); entries are broadcast in push order.
REQ-025 With simultaneous pushes and a pop, COUNT_next SHALL equal COUNT + pushes - pop, and pushing into an empty queue while popping SHALL not pop the new entry in the same edge.
REQ-026 FLUSH=1 at an edge SHALL reset head, tail and COUNT to 0 and SHALL override any same-cycle push and pop; OVERFLOW is unaffected.
REQ-027 CDB outputs SHALL hold stable while CDB_VALID=1 and CDB_READY=0.
REQ-028 Pointer wrap from DEPTH-1 to 0 SHALL be seamless, including a multi-push spanning the wrap.

Reset
REQ-029 RST=1 SHALL asynchronously force head=0, tail=0, COUNT=0, OVERFLOW=0, CDB_VALID=0, CDB_TAG=0, CDB_DATA=0, IN_READY=1.
REQ-030 Reset mid-operation SHALL discard all entries; the first edge after RST deasserts behaves as from an empty queue.
REQ-031 Storage array contents SHALL NOT require reset.

Verification (NUM_CH=4, DEPTH=16, TAG_W=4, DATA_W=32)
REQ-032 The bench SHALL drive IN_VALID=4'b1010, tags 3/5, data 0xA/0xB, into an empty queue with CDB_READY=1 -> next cycle CDB_TAG=3, DATA=0xA, COUNT=2; following cycle CDB_TAG=5, COUNT=1.
REQ-033 The bench SHALL hold CDB_READY=0 and drive all-valid pushes for 3 cycles -> COUNT=12, IN_READY=1; after a 4th cycle, COUNT=16, IN_READY=0, CDB outputs unchanged throughout.
REQ-034 The bench SHALL push while full (COUNT=13) -> COUNT stays 13, OVERFLOW=1, and OVERFLOW stays 1 after FLUSH until RST.
REQ-035 The bench SHALL advance the pointers to head=tail=14 and push 4 entries -> entries occupy slots 14,15,0,1 and pop in order with correct tags.
REQ-036 The bench SHALL assert FLUSH with a simultaneous push and pop at COUNT=5 -> COUNT=0, CDB_VALID=0, CDB_TAG=0 next cycle.
REQ-037 The bench SHALL pulse RST asynchronously between edges at COUNT=7 -> CDB_VALID=0 and COUNT=0 immediately, without waiting for CLK.
